dpu_datapath: RTL and testbench

- 8-bit datapath for the GRAFIX command/control unit: 16-entry register file, single ALU, condition codes, and a 24-bit pixel output bus.
- The controller drives register addresses (A, B, R), an opcode and immediate data every clock. The datapath executes one operation per rising edge.
- Pixel words (X, Y, colour) are published on Kbus whenever the controller toggles outEnable.

---
 rtl/dpu_pkg.sv | 38 +++
 rtl/dpu_if.sv | 24 ++
 rtl/dpu_alu.sv | 90 +++++++++
 rtl/dpu_datapath.sv | 92 +++++++++
 tb/tb_dpu_datapath.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dpu_pkg.sv
// Shared constants for the GRAFIX datapath: opcodes, fixed register map and
// condition-code bit positions.
package dpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SHL   = 4'd2;
  localparam logic [3:0] OP_SHR   = 4'd3;
  localparam logic [3:0] OP_PASS  = 4'd4;
  localparam logic [3:0] OP_PASS2 = 4'd5;
  localparam logic [3:0] OP_CMP   = 4'd6;
  localparam logic [3:0] OP_LOAD  = 4'd8;

  localparam logic [3:0] REG_DX     = 4'd0;
  localparam logic [3:0] REG_DY     = 4'd1;
  localparam logic [3:0] REG_ERROR  = 4'd2;
  localparam logic [3:0] REG_EINC   = 4'd3;
  localparam logic [3:0] REG_ENOINC = 4'd4;
  localparam logic [3:0] REG_XS     = 4'd5;
  localparam logic [3:0] REG_XE     = 4'd6;
  localparam logic [3:0] REG_YS     = 4'd7;
  localparam logic [3:0] REG_YE     = 4'd8;
  localparam logic [3:0] REG_X      = 4'd9;
  localparam logic [3:0] REG_Y      = 4'd10;
  localparam logic [3:0] REG_COLOUR = 4'd11;
  localparam logic [3:0] REG_ONE    = 4'd12;
  localparam logic [3:0] REG_ZERO   = 4'd13;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  function automatic logic is_const_reg(input logic [3:0] idx);
    return (idx == REG_ONE) || (idx == REG_ZERO);
  endfunction

endpackage

// File: rtl/dpu_if.sv
// Controller-to-datapath bus: register selects, opcode, immediate and publish
// request in; condition codes and pixel word out.
interface dpu_if #(parameter int W = 8) ();

  logic [3:0]     Abus;
  logic [3:0]     Bbus;
  logic [3:0]     Rbus;
  logic [3:0]     n;
  logic [W-1:0]   mData;
  logic           outEnable;
  logic [3:0]     cc;
  logic [3*W-1:0] Kbus;

  modport master (
    output Abus, Bbus, Rbus, n, mData, outEnable,
    input  cc, Kbus
  );

  modport slave (
    input  Abus, Bbus, Rbus, n, mData, outEnable,
    output cc, Kbus
  );

endinterface

// File: rtl/dpu_alu.sv
// Combinational ALU for the GRAFIX datapath. Signed-overflow (V) logic exists
// only when DPU_OVF_EN is defined; otherwise V is tied low.
module dpu_alu
  import dpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] result,
  output logic         we,
  output logic [3:0]   flags,
  output logic         flags_en
);

  logic [W:0] sum;
  logic [W:0] diff;
  logic       carry;
  logic       v;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // LOAD reports a write here; the top substitutes mData for the data.
  always_comb begin
    result   = '0;
    we       = 1'b0;
    carry    = 1'b0;
    flags_en = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum[W-1:0];
        carry    = sum[W];
        we       = 1'b1;
        flags_en = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        result   = diff[W-1:0];
        carry    = diff[W];
        we       = (op == OP_SUB);
        flags_en = 1'b1;
      end
      OP_SHL: begin
        result   = {a[W-2:0], 1'b0};
        carry    = a[W-1];
        we       = 1'b1;
        flags_en = 1'b1;
      end
      OP_SHR: begin
        result   = {1'b0, a[W-1:1]};
        carry    = a[0];
        we       = 1'b1;
        flags_en = 1'b1;
      end
      OP_PASS, OP_PASS2: begin
        result = a;
        we     = 1'b1;
      end
      OP_LOAD: begin
        we = 1'b1;
      end
      default: begin
        result = '0;
      end
    endcase
  end

`ifdef DPU_OVF_EN
  always_comb begin
    v = 1'b0;
    case (op)
      OP_ADD:         v = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
      OP_SUB, OP_CMP: v = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
      default:        v = 1'b0;
    endcase
  end
`else
  assign v = 1'b0;
`endif

  always_comb begin
    flags       = '0;
    flags[CC_N] = result[W-1];
    flags[CC_Z] = (result == '0);
    flags[CC_C] = carry;
    flags[CC_V] = v;
  end

endmodule

// File: rtl/dpu_datapath.sv
// GRAFIX datapath top: 16-entry register file with constant 1/0 slots, ALU,
// registered condition codes and toggle-triggered pixel publish on Kbus.
// Optional macro DPU_OVF_EN enables the V flag.
module dpu_datapath
  import dpu_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREG = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  dpu_if.slave  bus
);

  logic [W-1:0]   regs [NREG];
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   alu_result;
  logic           alu_we;
  logic [3:0]     alu_flags;
  logic           alu_flags_en;
  logic [W-1:0]   wdata;
  logic           wen;
  logic [3:0]     cc_q;
  logic [3*W-1:0] kbus_q;
  logic           oe_q;

  function automatic logic [W-1:0] read_reg(input logic [3:0] idx);
    if (idx == REG_ONE)
      return W'(1);
    else if (idx == REG_ZERO)
      return '0;
    else
      return regs[idx];
  endfunction

  // Publish snapshot sees this edge's write to X/Y/Colour, not the old value.
  function automatic logic [W-1:0] next_reg(input logic [3:0] idx);
    if (wen && (bus.Rbus == idx))
      return wdata;
    else
      return regs[idx];
  endfunction

  assign op_a = read_reg(bus.Abus);
  assign op_b = read_reg(bus.Bbus);

  dpu_alu #(.W(W)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (bus.n),
    .result   (alu_result),
    .we       (alu_we),
    .flags    (alu_flags),
    .flags_en (alu_flags_en)
  );

  assign wdata = (bus.n == OP_LOAD) ? bus.mData : alu_result;
  assign wen   = alu_we && !is_const_reg(bus.Rbus);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wen) begin
      regs[bus.Rbus] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cc_q <= '0;
    else if (alu_flags_en)
      cc_q <= alu_flags;
  end

  // Any level change of outEnable relative to the last sampled level publishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q   <= 1'b0;
      kbus_q <= '0;
    end else begin
      oe_q <= bus.outEnable;
      if (bus.outEnable != oe_q)
        kbus_q <= {next_reg(REG_X), next_reg(REG_Y), next_reg(REG_COLOUR)};
    end
  end

  assign bus.cc   = cc_q;
  assign bus.Kbus = kbus_q;

endmodule

// File: tb/tb_dpu_datapath.sv
// Scoreboard bench for dpu_datapath: directed ops queue expected cc/Kbus
// values; a negedge monitor pops and compares them after each executing edge.
module tb_dpu_datapath;

  typedef struct {
    string       name;
    int          at;
    bit          isK;
    logic [23:0] exp;
  } item_t;

`ifdef DPU_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic  clk;
  logic  rst_n;
  int    edgeCount;
  int    compared;
  int    mismatched;
  item_t sb[$];

  dpu_if ifc ();

  dpu_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edgeCount = 0;
    forever begin
      @(posedge clk);
      edgeCount++;
    end
  end

  task automatic checkOutput(input string name, input bit isK, input logic [23:0] exp);
    logic [23:0] act;
    act = isK ? ifc.Kbus : {20'h0, ifc.cc};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edgeCount) begin
        it = sb.pop_front();
        checkOutput(it.name, it.isK, it.exp);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic [3:0] r,
                               input logic [7:0] d, input logic oe,
                               input logic [3:0] expCc, input logic [23:0] expK,
                               input string name);
    item_t it;
    ifc.n         = op;
    ifc.Abus      = a;
    ifc.Bbus      = b;
    ifc.Rbus      = r;
    ifc.mData     = d;
    ifc.outEnable = oe;
    it.at   = edgeCount + 1;
    it.name = {name, "_cc"};
    it.isK  = 1'b0;
    it.exp  = {20'h0, expCc};
    sb.push_back(it);
    it.name = {name, "_kbus"};
    it.isK  = 1'b1;
    it.exp  = expK;
    sb.push_back(it);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    ifc.n         = 4'd7;
    ifc.Abus      = 4'd0;
    ifc.Bbus      = 4'd0;
    ifc.Rbus      = 4'd0;
    ifc.mData     = 8'h00;
    ifc.outEnable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_cc", 1'b0, 24'h0);
    checkOutput("reset_kbus", 1'b1, 24'h0);
    rst_n = 1'b1;

    //            op     A      B      R      data   oe    cc              Kbus
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd5,  8'h05, 1'b0, 4'h0,           24'h000000, "load_r5");
    applyStimulus(4'd4,  4'd5,  4'd0,  4'd11, 8'h00, 1'b1, 4'h0,           24'h000005, "read_r5");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd8,  8'h0A, 1'b1, 4'h0,           24'h000005, "load_r8");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd7,  8'h03, 1'b1, 4'h0,           24'h000005, "load_r7");
    applyStimulus(4'd1,  4'd8,  4'd7,  4'd1,  8'h00, 1'b1, 4'h0,           24'h000005, "sub_r1");
    applyStimulus(4'd4,  4'd1,  4'd0,  4'd11, 8'h00, 1'b0, 4'h0,           24'h000007, "read_r1");
    applyStimulus(4'd2,  4'd1,  4'd0,  4'd4,  8'h00, 1'b0, 4'h0,           24'h000007, "shl_r4");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd0,  8'h10, 1'b0, 4'h0,           24'h000007, "load_r0");
    applyStimulus(4'd1,  4'd4,  4'd0,  4'd2,  8'h00, 1'b0, 4'hA,           24'h000007, "sub_neg");
    applyStimulus(4'd4,  4'd2,  4'd0,  4'd11, 8'h00, 1'b1, 4'hA,           24'h0000FE, "read_r2");
    applyStimulus(4'd6,  4'd2,  4'd13, 4'd14, 8'h00, 1'b1, 4'h8,           24'h0000FE, "cmp_neg");
    applyStimulus(4'd4,  4'd14, 4'd0,  4'd11, 8'h00, 1'b0, 4'h8,           24'h000000, "read_r14");
    applyStimulus(4'd6,  4'd12, 4'd13, 4'd14, 8'h00, 1'b0, 4'h0,           24'h000000, "cmp_pos");
    applyStimulus(4'd6,  4'd13, 4'd12, 4'd14, 8'h00, 1'b0, 4'hA,           24'h000000, "cmp_borrow");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd9,  8'h12, 1'b0, 4'hA,           24'h000000, "load_r9");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd10, 8'h34, 1'b0, 4'hA,           24'h000000, "load_r10");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd11, 8'h56, 1'b1, 4'hA,           24'h123456, "pub_load");
    applyStimulus(4'd7,  4'd0,  4'd0,  4'd0,  8'h00, 1'b1, 4'hA,           24'h123456, "hold");
    applyStimulus(4'd0,  4'd9,  4'd12, 4'd9,  8'h00, 1'b1, 4'h0,           24'h123456, "add_r9");
    applyStimulus(4'd7,  4'd0,  4'd0,  4'd0,  8'h00, 1'b0, 4'h0,           24'h133456, "pub_toggle0");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd15, 8'hFF, 1'b0, 4'h0,           24'h133456, "load_r15");
    applyStimulus(4'd0,  4'd15, 4'd12, 4'd9,  8'h00, 1'b1, 4'h6,           24'h003456, "add_wrap_pub");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd12, 8'h77, 1'b1, 4'h6,           24'h003456, "load_r12");
    applyStimulus(4'd0,  4'd12, 4'd12, 4'd10, 8'h00, 1'b0, 4'h0,           24'h000256, "read_const1");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd13, 8'h55, 1'b0, 4'h0,           24'h000256, "load_r13");
    applyStimulus(4'd4,  4'd13, 4'd0,  4'd11, 8'h00, 1'b1, 4'h0,           24'h000200, "read_const0");
    applyStimulus(4'd8,  4'd0,  4'd0,  4'd14, 8'h7F, 1'b1, 4'h0,           24'h000200, "load_r14");
    applyStimulus(4'd0,  4'd14, 4'd12, 4'd14, 8'h00, 1'b1, {3'b100, OVF},  24'h000200, "add_ovf");
    applyStimulus(4'd1,  4'd14, 4'd12, 4'd15, 8'h00, 1'b1, {3'b000, OVF},  24'h000200, "sub_ovf");
    applyStimulus(4'd3,  4'd15, 4'd0,  4'd3,  8'h00, 1'b1, 4'h2,           24'h000200, "shr_r3");
    applyStimulus(4'd4,  4'd3,  4'd0,  4'd11, 8'h00, 1'b0, 4'h2,           24'h00023F, "read_r3");
    applyStimulus(4'd5,  4'd5,  4'd0,  4'd11, 8'h00, 1'b1, 4'h2,           24'h000205, "pass2");
    applyStimulus(4'd15, 4'd3,  4'd0,  4'd11, 8'h00, 1'b0, 4'h2,           24'h000205, "nop15");
    applyStimulus(4'd9,  4'd1,  4'd1,  4'd9,  8'hAA, 1'b1, 4'h2,           24'h000205, "nop9");

    // Asynchronous reset in the middle of a LOAD: outputs clear before any edge.
    ifc.n     = 4'd8;
    ifc.Rbus  = 4'd10;
    ifc.mData = 8'hAA;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_cc", 1'b0, 24'h0);
    checkOutput("async_reset_kbus", 1'b1, 24'h0);
    ifc.outEnable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'd8,  4'd0,  4'd0,  4'd9,  8'h21, 1'b1, 4'h0,           24'h210000, "post_reset_load");
    applyStimulus(4'd4,  4'd5,  4'd0,  4'd11, 8'h00, 1'b0, 4'h0,           24'h210000, "post_reset_regs");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
